// File: rtl/line_memory_pkg.sv
// line_memory_pkg: shared widths, FSM states and the latched request payload for line_memory.
package line_memory_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic              err;
        logic [LINE_W-1:0] data;
    } req_t;

endpackage

// File: rtl/line_memory_array.sv
// line_memory_array: DEPTH x LINE_W line storage, synchronous write, registered read.
// Storage is never reset; only the read register clears on reset.
module line_memory_array
    import line_memory_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wr_data,
    output logic [LINE_W-1:0] rd_data
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end

    // Read register holds the last completed read; rd_clr returns an all-zero line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_clr ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/line_memory.sv
// line_memory: 256-bit line backing store with a fixed LATENCY and a one-cycle ack pulse.
// Optional address range checking is compiled in with LINE_MEMORY_RANGE_CHECK_EN.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned      IDX_W    = $clog2(DEPTH);
    localparam int unsigned      TOP_LSB  = OFFSET_W + IDX_W;
    localparam bit               DIRECT   = (LATENCY == 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [IDX_W-1:0] idx_raw_c, idx_c, idx_q, acc_idx_c;
    logic             idx_over_c;
    logic             err_c;
    logic             unused_addr;
    req_t             req_c, req_q, acc_req_c;
    logic             accept_c, commit_c;

    assign idx_raw_c  = addr_i[OFFSET_W +: IDX_W];
    assign idx_over_c = ({1'b0, idx_raw_c} >= (IDX_W + 1)'(DEPTH));
    // Non-power-of-two depths fold the single overflow range back into the array.
    assign idx_c      = idx_over_c ? (idx_raw_c - IDX_W'(DEPTH)) : idx_raw_c;

`ifdef LINE_MEMORY_RANGE_CHECK_EN
    assign err_c       = (addr_i[ADDR_W-1:TOP_LSB] != '0) || idx_over_c;
    assign unused_addr = ^addr_i[OFFSET_W-1:0];
`else
    assign err_c       = 1'b0;
    assign unused_addr = ^{addr_i[ADDR_W-1:TOP_LSB], addr_i[OFFSET_W-1:0]};
`endif

    assign req_c = '{write: write_i, err: err_c, data: data_i};

    // With a one-cycle latency the access happens on the acceptance edge itself.
    assign acc_req_c = DIRECT ? req_c : req_q;
    assign acc_idx_c = DIRECT ? idx_c : idx_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept_c   = 1'b0;
        commit_c   = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i) begin
                    accept_c = 1'b1;
                    cnt_next = CNT_LOAD;
                    if (DIRECT) begin
                        commit_c   = 1'b1;
                        state_next = ACK;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    commit_c   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            ack_o  <= 1'b0;
            busy_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            ack_o  <= (state_next == ACK);
            busy_o <= (state_next != IDLE);
            err_o  <= commit_c & acc_req_c.err;
        end
    end

    // Request latch: the captured request is authoritative until the ack.
    always_ff @(posedge clk_i) begin
        if (accept_c) begin
            req_q <= req_c;
            idx_q <= idx_c;
        end
    end

    line_memory_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .wr_en   (commit_c & acc_req_c.write & ~acc_req_c.err),
        .rd_en   (commit_c & ~acc_req_c.write),
        .rd_clr  (acc_req_c.err),
        .idx     (acc_idx_c),
        .wr_data (acc_req_c.data),
        .rd_data (data_o)
    );

endmodule

// File: tb/tb_line_memory.sv
// tb_line_memory: drives two line_memory instances (LATENCY 10 and 4) with one directed
// stimulus stream and checks them against a timing/transaction model every cycle.
module tb_line_memory;

    localparam int unsigned DEPTH = 512;
`ifdef LINE_MEMORY_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_i = 1'b1;
    logic         en    = 1'b0;
    logic         we    = 1'b0;
    logic [31:0]  addr  = '0;
    logic [255:0] din   = '0;
    logic [255:0] dout [2];
    logic         ack  [2];
    logic         busy [2];
    logic         err  [2];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_memory #(.DEPTH(DEPTH), .LATENCY(10)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .enable_i(en), .write_i(we), .addr_i(addr), .data_i(din),
        .data_o(dout[0]), .ack_o(ack[0]), .busy_o(busy[0]), .err_o(err[0]));

    line_memory #(.DEPTH(DEPTH), .LATENCY(4)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .enable_i(en), .write_i(we), .addr_i(addr), .data_i(din),
        .data_o(dout[1]), .ack_o(ack[1]), .busy_o(busy[1]), .err_o(err[1]));

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Transaction model: a request accepted in cycle T acks in cycle T+L and is busy T+1..T+L.
    int           acc_t [2] = '{-100, -100};
    int           ack_t [2] = '{-100, -100};
    logic [31:0]  m_addr [2];
    bit           m_wr   [2];
    logic [255:0] m_data [2];
    bit           m_err  [2];
    logic [255:0] exp_data  [2] = '{default: '0};
    bit           exp_known [2] = '{1'b1, 1'b1};
    logic [255:0] mem_m [2][DEPTH];
    bit           mem_v [2][DEPTH];

    function automatic int lat(input int i);
        return (i == 0) ? 10 : 4;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32) % DEPTH);
    endfunction

    function automatic bit range_err(input logic [31:0] a);
        return RC && (a >= 32'(DEPTH * 32));
    endfunction

    function automatic void commit(input int i);
        int ln;
        ln = line_of(m_addr[i]);
        if (m_wr[i]) begin
            if (!m_err[i]) begin
                mem_m[i][ln] = m_data[i];
                mem_v[i][ln] = 1'b1;
            end
        end else if (m_err[i]) begin
            exp_data[i]  = '0;
            exp_known[i] = 1'b1;
        end else begin
            exp_data[i]  = mem_m[i][ln];
            exp_known[i] = mem_v[i][ln];
        end
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                if (en && cyc > ack_t[i]) begin
                    acc_t[i]  = cyc;
                    ack_t[i]  = cyc + lat(i);
                    m_addr[i] = addr;
                    m_wr[i]   = we;
                    m_data[i] = din;
                    m_err[i]  = range_err(addr);
                end
                if (cyc == ack_t[i] - 1) commit(i);
            end
        end
        cyc++;
    end

    always @(negedge rst_i) begin
        for (int i = 0; i < 2; i++) begin
            acc_t[i]     = -100;
            ack_t[i]     = -100;
            exp_data[i]  = '0;
            exp_known[i] = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit a_e;
            a_e = (cyc == ack_t[i]);
            chk($sformatf("ack%0d@%0d", i, cyc), 256'(ack[i]), 256'(a_e));
            chk($sformatf("busy%0d@%0d", i, cyc), 256'(busy[i]), 256'((cyc > acc_t[i]) && (cyc <= ack_t[i])));
            chk($sformatf("err%0d@%0d", i, cyc), 256'(err[i]), 256'(a_e && m_err[i]));
            if (exp_known[i]) chk($sformatf("data%0d@%0d", i, cyc), dout[i], exp_data[i]);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [255:0] r_data  [2];
    bit           r_err   [2];
    int           r_nack  [2];
    int           r_first [2];
    int           r_nbusy [2];

    // One request, then 12 idle cycles recording ack count, first-ack offset, data and err.
    task automatic xact(input bit wr, input logic [31:0] a, input logic [255:0] d, input bit scramble);
        for (int i = 0; i < 2; i++) begin
            r_data[i] = '0; r_err[i] = 1'b0; r_nack[i] = 0; r_first[i] = -1; r_nbusy[i] = 0;
        end
        en = 1'b1; we = wr; addr = a; din = d;
        tick();
        en = 1'b0; we = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (scramble) begin
                addr = 32'h200; we = k[0]; din = ~d;
            end
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    r_nack[i]++;
                    if (r_first[i] < 0) r_first[i] = k;
                    r_data[i] = dout[i];
                    r_err[i]  = err[i];
                end
                if (busy[i]) r_nbusy[i]++;
            end
            tick();
        end
        we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        $fatal(1);
    end

    initial begin
        logic [255:0] pa5, pq, pp2, px1, px2, pz, pr;
        int n0, n1, last1, gap1;
        pa5 = {32{8'hA5}};
        pq  = {8{32'h1234_5678}};
        pp2 = {8{32'hDEAD_BEEF}};
        px1 = {8{32'h0F0F_0F0F}};
        px2 = {8{32'hCAFE_F00D}};
        pz  = {8{32'h5555_AAAA}};
        pr  = {8{32'h1357_9BDF}};

        #1 rst_i = 1'b0;
        repeat (3) tick();
        chk("rst_ack0", 256'(ack[0]), 256'(0));
        chk("rst_busy1", 256'(busy[1]), 256'(0));
        chk("rst_data0", dout[0], 256'(0));
        rst_i = 1'b1;
        tick(); tick();

        xact(1'b0, 32'h0000_0040, '0, 1'b0);
        chk("lat_first0", 256'(r_first[0]), 256'(10));
        chk("lat_nack0", 256'(r_nack[0]), 256'(1));
        chk("lat_nbusy0", 256'(r_nbusy[0]), 256'(10));
        chk("lat_first1", 256'(r_first[1]), 256'(4));

        xact(1'b1, 32'h0000_0100, pa5, 1'b0);
        chk("wr_nack0", 256'(r_nack[0]), 256'(1));
        xact(1'b0, 32'h0000_011C, '0, 1'b0);
        chk("wr_rd_data0", r_data[0], pa5);
        chk("wr_rd_data1", r_data[1], pa5);

        xact(1'b1, 32'h0000_0200, pq, 1'b0);
        xact(1'b1, 32'h0000_0300, pp2, 1'b1);
        chk("latch_nack0", 256'(r_nack[0]), 256'(1));
        chk("latch_nack1", 256'(r_nack[1]), 256'(1));
        xact(1'b0, 32'h0000_0200, '0, 1'b0);
        chk("latch_other0", r_data[0], pq);
        xact(1'b0, 32'h0000_0300, '0, 1'b0);
        chk("latch_orig0", r_data[0], pp2);
        chk("latch_orig1", r_data[1], pp2);

        // enable held through cycles s..s+39
        n0 = 0; n1 = 0; last1 = -100; gap1 = 1000;
        en = 1'b1; we = 1'b0; addr = 32'h0000_0300;
        for (int k = 0; k <= 44; k++) begin
            if (k >= 1) begin
                if (ack[0]) n0++;
                if (ack[1]) begin
                    n1++;
                    if (k - last1 < gap1) gap1 = k - last1;
                    last1 = k;
                end
            end
            en = (k <= 38);
            tick();
        end
        chk("held_nack0", 256'(n0), 256'(4));
        chk("held_nack1", 256'(n1), 256'(8));
        chk("held_gap1", 256'(gap1), 256'(5));

        xact(1'b1, 32'h0000_00C0, px1, 1'b0);
        n0 = 0; n1 = 0;
        en = 1'b1; we = 1'b1; addr = 32'h0000_00C0; din = px2;
        tick();
        en = 1'b0; we = 1'b0;
        for (int k = 1; k < 5; k++) begin
            if (ack[0]) n0++;
            if (ack[1]) n1++;
            tick();
        end
        rst_i = 1'b0;
        tick();
        chk("rstmid_busy0", 256'(busy[0]), 256'(0));
        chk("rstmid_ack0", 256'(ack[0]), 256'(0));
        chk("rstmid_data0", dout[0], 256'(0));
        tick();
        rst_i = 1'b1;
        tick(); tick();
        chk("rstmid_nack0", 256'(n0), 256'(0));
        chk("rstmid_nack1", 256'(n1), 256'(1));
        xact(1'b0, 32'h0000_00C0, '0, 1'b0);
        chk("rstmid_keep0", r_data[0], px1);
        chk("rstmid_new1", r_data[1], px2);

        xact(1'b1, 32'h0000_0000, pz, 1'b0);
        xact(1'b1, 32'h0000_4000, pr, 1'b0);
        chk("range_err0", 256'(r_err[0]), 256'(RC));
        chk("range_nack0", 256'(r_nack[0]), 256'(1));
        xact(1'b0, 32'h0000_0000, '0, 1'b0);
        chk("range_line0", r_data[0], RC ? pz : pr);
        xact(1'b0, 32'h0000_4000, '0, 1'b0);
        chk("range_rd_data0", r_data[0], RC ? 256'(0) : pr);
        chk("range_rd_err1", 256'(r_err[1]), 256'(RC));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_memory.md
# line_memory

Line-granular backing memory that sits directly downstream of the CPU's data-cache controller and serves its miss/write-back traffic. Each request moves one 256-bit cache line after a fixed, parameterised latency and completes with a one-cycle `ack_o` pulse. The block is the storage endpoint on the `mem_*` bus driven by the CPU top and replaces the earlier word-wide data memory.

## Interface
- `DEPTH`, 512: number of 256-bit lines stored.
- `LATENCY`, 10: cycles from request acceptance to `ack_o`; legal range 1..255.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  request valid; maps to the CPU's `mem_enable_o`.
- `write_i`  in  1  1 = write line, 0 = read line; maps to `mem_write_o`.
- `addr_i`  in  32  byte address; bits [4:0] ignored; line index = `addr_i[5 +: $clog2(DEPTH)]`.
- `data_i`  in  256  write line data; maps to `mem_data_o`.
- `data_o`  out  256  read line data; maps to `mem_data_i`.
- `ack_o`  out  1  one-cycle completion pulse; maps to `mem_ack_i`.
- `busy_o`  out  1  high whenever the block is not IDLE.
- `err_o`  out  1  out-of-range flag, valid with `ack_o` (see Configuration).

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: when `enable_i`=1, latch `addr_i`, `write_i`, `data_i`, and load counter = `LATENCY`-1.
  - If `LATENCY`=1, go directly to ACK.
  - Otherwise go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 0, perform the array access and go to ACK.
  - Read: `data_o` <= array[idx].
  - Write: array[idx] <= latched data. `data_o` is unchanged.
- ACK: `ack_o`=1 for exactly this cycle. Return to IDLE. `enable_i` is ignored in this state.
- Inputs are ignored outside IDLE. The latched request is authoritative.
- `data_o` is registered. It holds the last read line until the next read completes.
- The line index wraps modulo `DEPTH`. Upper address bits are discarded unless the range check is compiled in.
- The array is not reset. Its contents survive `rst_i`.

## Timing
- Reset values: state IDLE; `ack_o`=0, `busy_o`=0, `err_o`=0, `data_o`=0, counter=0.
- Request sampled at edge T (IDLE, `enable_i`=1). `ack_o` is high during cycle T+`LATENCY`. `busy_o` is high from T+1 through the ACK cycle.
- A write is visible to a read accepted in any later IDLE cycle.
- If `enable_i` is held high continuously, a new request is accepted in the IDLE cycle after ACK. Throughput is one request per `LATENCY`+1 cycles.
- Reset asserted mid-request: the FSM returns to IDLE at once and no `ack_o` is issued. A write that has not yet reached its commit edge is dropped.

## Configuration
- `LINE_MEMORY_RANGE_CHECK_EN` defined:
  - Address bits above the index that are non-zero, or an index ≥ `DEPTH`, set `err_o`=1 during the ACK cycle.
  - Writes are suppressed; reads return all-zero.
  - `ack_o` is still issued.
- Not defined: `err_o` is tied to 0 and addresses wrap as described.

## Structure
- Package `line_memory_pkg` contains:
  - the state enum (IDLE/WAIT/ACK);
  - `LINE_W`=256 and `OFFSET_W`=5;
  - the counter width (8 bits).
- Sub-module `line_memory_array`: `DEPTH`×256 storage with synchronous write and registered read, no reset. The FSM, counter, request latch and range check live in `line_memory`.

## Test plan
- Latency: with `LATENCY`=10, read of 0x0000_0040 accepted at cycle 0 → `ack_o` high only in cycle 10; `busy_o` high in cycles 1–10.
- Write then read: write 0xA5A5…A5 (256 bits) to 0x0000_0100; after its ack, read 0x0000_011C → `data_o`=0xA5A5…A5 with the ack; offset bits are ignored.
- Latch stability: during WAIT, change `addr_i` to 0x200 and toggle `write_i` → the completed access uses the original request; exactly one ack.
- Held enable: hold `enable_i`=1 for 40 cycles with `LATENCY`=4 → acks at cycles 4, 9, 14, …; never two acks within 5 cycles.
- Reset mid-request: assert `rst_i`=0 at cycle 5 of a write with `LATENCY`=10 → no ack; all outputs return to reset values; a later read of that line returns the prior contents.
- Range check (macro defined, `DEPTH`=512): write to 0x0000_4000 → `err_o`=1 with `ack_o`; a subsequent read of 0x0000_0000 is unchanged. Without the macro, the same write lands at line 0.
